// File: rtl/input_holder_pkg.sv
// Shared types for the input holder and its neighbours: interface FSM states and
// the holder's own state encoding.
package input_holder_pkg;

  typedef enum logic [1:0] {
    I_IDLE,
    I_LOAD_KEY,
    I_ENCRYPT,
    I_DRAIN
  } interface_state_t;

  typedef enum logic [1:0] {
    H_EMPTY,
    H_FULL,
    H_SENT
  } input_holder_state_t;

endpackage

// File: rtl/input_holder_if.sv
// Pin-side handshake plus cipher-side delivery signals of the input holder.
interface input_holder_if
  import input_holder_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0]   pin_data;
  logic                pin_strobe;
  logic                pin_is_key;
  interface_state_t    interface_state;
  logic                cipher_ready;
  logic [DATA_W-1:0]   data_out;
  logic                data_pulse;
  logic                key_pulse;
  logic                pin_ack;
  input_holder_state_t input_holder_state_out;

  modport master (
    output pin_data, pin_strobe, pin_is_key, interface_state, cipher_ready,
    input  data_out, data_pulse, key_pulse, pin_ack, input_holder_state_out
  );

  modport slave (
    input  pin_data, pin_strobe, pin_is_key, interface_state, cipher_ready,
    output data_out, data_pulse, key_pulse, pin_ack, input_holder_state_out
  );

endinterface

// File: rtl/input_holder_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level with a registered-history
// rising-edge output; reusable for any pin input.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/input_holder.sv
// Captures a user byte on a synchronized strobe rise, hands it to the cipher as a
// one-cycle data/key pulse, then acks the user until the strobe drops.
module input_holder
  import input_holder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input_holder_if.slave   bus
);

  logic                w_sync;
  logic                w_rise;
  logic                w_capture;
  logic                w_send;
  input_holder_state_t w_state_next;

  input_holder_state_t r_state;
  logic [DATA_W-1:0]   r_data;
  logic                r_is_key;
  logic                r_data_pulse;
  logic                r_key_pulse;
  logic                r_ack;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.pin_strobe),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  // Abort outranks cipher_ready while a byte is waiting.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_send       = 1'b0;
    unique case (r_state)
      H_EMPTY: begin
        if (w_rise) begin
          w_capture    = 1'b1;
          w_state_next = H_FULL;
        end
      end
      H_FULL: begin
        if (bus.interface_state == I_IDLE) begin
          w_state_next = H_EMPTY;
        end else if (bus.cipher_ready) begin
          w_send       = 1'b1;
          w_state_next = H_SENT;
        end
      end
      H_SENT: begin
        if (!w_sync) w_state_next = H_EMPTY;
      end
      default: w_state_next = H_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= H_EMPTY;
      r_data       <= '0;
      r_is_key     <= 1'b0;
      r_data_pulse <= 1'b0;
      r_key_pulse  <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_data_pulse <= w_send & ~r_is_key;
      r_key_pulse  <= w_send & r_is_key;
      r_ack        <= (w_state_next == H_SENT);
      if (w_capture) begin
        r_data   <= bus.pin_data;
        r_is_key <= bus.pin_is_key;
      end
    end
  end

  assign bus.data_out               = r_data;
  assign bus.data_pulse             = r_data_pulse;
  assign bus.key_pulse              = r_key_pulse;
  assign bus.pin_ack                = r_ack;
  assign bus.input_holder_state_out = r_state;

endmodule

// File: doc/input_holder.md
Name: input_holder

Overview:
- Receives bytes from the chip user through a four-phase strobe/ack handshake on the input pins.
- Synchronizes the asynchronous strobe and captures the byte together with its key/plaintext tag.
- Delivers the byte to the encryption block as a one-cycle pulse once the cipher is ready.
- Sits between the input pins and the stream cipher core, and reports its state to the interface FSM.

Parameters:
- SYNC_STAGES, 2, number of flops in the strobe synchronizer (minimum 2).
- DATA_W, 8, byte width of pin_data and data_out.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pin_data  input  DATA_W  user byte from pins; user holds it stable while pin_strobe is high
- pin_strobe  input  1  user request, asynchronous level
- pin_is_key  input  1  1 = byte is key material, 0 = plaintext; held stable with pin_data
- interface_state  input  interface_state_t  state of interface FSM
- cipher_ready  input  1  encryption block can accept a byte this cycle
- data_out  output  DATA_W  held byte to cipher
- data_pulse  output  1  one-cycle strobe: data_out is plaintext
- key_pulse  output  1  one-cycle strobe: data_out is key byte
- pin_ack  output  1  ack to user; user drops pin_strobe after seeing it
- input_holder_state_out  output  input_holder_state_t  current state, to interface FSM

Behaviour:
- Reset:
  - The sync chain, edge-detect flop, data_out, is_key flag, data_pulse, key_pulse and pin_ack all go to 0.
  - State goes to H_EMPTY.
  - Reset overrides everything in the same edge.
- Synchronizer:
  - pin_strobe passes through SYNC_STAGES flops; s_sync is the last stage.
  - rise = s_sync & ~s_prev, where s_prev is s_sync delayed one cycle.
- States (input_holder_state_t): H_EMPTY, H_FULL, H_SENT.
- H_EMPTY:
  - On rise, capture pin_data into data_out and pin_is_key into the flag; go to H_FULL.
  - Latency with SYNC_STAGES=2: strobe high before edge 0 gives state H_FULL after edge 2.
- H_FULL:
  - When cipher_ready=1, at the next edge assert key_pulse if the flag is 1, otherwise data_pulse, for exactly one cycle; go to H_SENT.
  - When cipher_ready=0, hold with no pulse and no time limit.
- H_SENT:
  - pin_ack=1 (registered, high throughout H_SENT).
  - When s_sync=0, go to H_EMPTY and drop pin_ack at the same edge.
- data_out holds the last captured byte until the next capture; it does not clear on pulse or on abort.
- Abort: if interface_state == I_IDLE while in H_FULL, go to H_EMPTY at the next edge.
  - No pulse is issued, and pin_ack does not rise.
  - Abort has priority over cipher_ready in the same cycle.
  - I_IDLE in H_SENT is not an abort; H_SENT completes normally.
- Retrigger safety:
  - Only a rising edge captures, so a strobe held high across an abort never recaptures.
  - The user must drop and re-raise the strobe.
  - A rise seen in H_FULL or H_SENT is ignored.
- Reset mid-transfer:
  - Because the sync chain clears, a strobe held high through reset is seen as a fresh rise SYNC_STAGES+1 cycles after rst falls, and is captured. This is intended: the user byte is re-delivered.
- Pulses: data_pulse and key_pulse are mutually exclusive, registered, never high for two consecutive cycles.
- Glitch: a strobe pulse shorter than one clock may be missed. The user protocol requires holding the strobe until pin_ack.

Decomposition:
- types_pkg gains input_holder_state_t {H_EMPTY, H_FULL, H_SENT}.
- interface_state_t, including I_IDLE, is already in types_pkg and is reused.
- Sub-module: sync_edge_detect, holding the parameterized synchronizer plus rise output. It is reusable for other pin inputs.
- The FSM, data register and pulse generation stay in input_holder.

Test Plan:
- Basic plaintext:
  - Stimulus: pin_data=0xA5, is_key=0, raise strobe, cipher_ready=1.
  - Response: H_FULL after 2 edges; data_pulse high for one cycle with data_out=0xA5; key_pulse=0; pin_ack=1.
  - Then drop strobe: pin_ack=0 and H_EMPTY within 3 edges.
- Key byte with stall:
  - Stimulus: 0x3C, is_key=1, cipher_ready=0 for 10 cycles, then 1.
  - Response: no pulse for 10 cycles; then exactly one key_pulse with data_out=0x3C.
- Abort:
  - Stimulus: capture 0x11, hold cipher_ready=0, then interface_state=I_IDLE for one cycle and keep the strobe high.
  - Response: H_EMPTY, no pulses, pin_ack=0.
  - Then cipher_ready=1: still no capture until the strobe falls and rises again.
- Abort vs ready:
  - Stimulus: I_IDLE and cipher_ready=1 in the same cycle while in H_FULL.
  - Response: no pulse, state H_EMPTY.
- Ignored rise:
  - Stimulus: in H_FULL, change pin_data to 0x77 and glitch the strobe low then high.
  - Response: data_out stays at the original byte, and the single pulse carries that original byte.
- Reset mid-transfer:
  - Stimulus: assert rst in H_SENT with the strobe held high.
  - Response: all outputs 0, H_EMPTY.
  - After rst falls: recapture after 3 edges and one new pulse.
